// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: register-index width and the
// per-slot producer record.
package forward_scoreboard_pkg;

  localparam int unsigned REG_W       = 5;
  // Slot data storage width; the module's XLEN must not exceed it.
  localparam int unsigned SLOT_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    logic [REG_W-1:0]       dest;
    logic                   ready;
    logic [SLOT_DATA_W-1:0] data;
  } scoreboardSlot_;

endpackage : forward_scoreboard_pkg

// File: rtl/forward_scoreboard_if.sv
// Issue, late-result, operand-read and forwarding signals of the scoreboard.
interface forward_scoreboard_if #(
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned XLEN     = 32
) ();
  import forward_scoreboard_pkg::*;

  logic                             advance;
  logic                             flush;
  logic                             issueValid;
  logic [REG_W-1:0]                 issueDest;
  logic                             issueReady;
  logic [XLEN-1:0]                  issueData;
  logic                             lateValid;
  logic [REG_W-1:0]                 lateDest;
  logic [XLEN-1:0]                  lateData;
  logic [NUM_READ-1:0][REG_W-1:0]   readRegister;
  logic [NUM_READ-1:0]              forwardEnable;
  logic [NUM_READ-1:0][XLEN-1:0]    forwardData;
  logic                             stall;

  modport master (
    output advance, flush, issueValid, issueDest, issueReady, issueData,
           lateValid, lateDest, lateData, readRegister,
    input  forwardEnable, forwardData, stall
  );

  modport slave (
    input  advance, flush, issueValid, issueDest, issueReady, issueData,
           lateValid, lateDest, lateData, readRegister,
    output forwardEnable, forwardData, stall
  );

endinterface : forward_scoreboard_if

// File: rtl/forward_scoreboard_match.sv
// One read port: pick the youngest in-flight producer of read_reg and decide
// forward / late-forward / stall.
module forward_match
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LATE_STAGE = 1,
  parameter int unsigned XLEN       = 32
) (
  input  scoreboardSlot_   slots [DEPTH],
  input  logic [REG_W-1:0] read_reg,
  input  logic             late_valid,
  input  logic [REG_W-1:0] late_dest,
  input  logic [XLEN-1:0]  late_data,
  output logic             fwd_en_c,
  output logic [XLEN-1:0]  fwd_data_c,
  output logic             stall_c
);

  logic found;

  // Slot 0 is youngest, so the first hit in ascending order wins.
  always_comb begin
    fwd_en_c   = 1'b0;
    fwd_data_c = '0;
    stall_c    = 1'b0;
    found      = 1'b0;
    if (read_reg != '0) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!found && slots[i].valid && (slots[i].dest == read_reg)) begin
          found = 1'b1;
          if (slots[i].ready) begin
            fwd_en_c   = 1'b1;
            fwd_data_c = slots[i].data[XLEN-1:0];
          end else if ((i == LATE_STAGE) && late_valid && (late_dest == read_reg)) begin
            fwd_en_c   = 1'b1;
            fwd_data_c = late_data;
          end else begin
            stall_c = 1'b1;
          end
        end
      end
    end
  end

endmodule : forward_match

// File: rtl/forward_scoreboard.sv
// In-flight producer tracker with zero-latency operand forwarding and
// load-use stall detection.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LATE_STAGE = 1,
  parameter int unsigned XLEN       = 32
) (
  input logic               clock,
  input logic               reset,
  forward_scoreboard_if.slave sb
);

  scoreboardSlot_ slot_q [DEPTH];
  scoreboardSlot_ slot_d [DEPTH];
  scoreboardSlot_ cap    [DEPTH];

  logic [NUM_READ-1:0]            port_stall;
  logic [NUM_READ-1:0]            fwd_en;
  logic [NUM_READ-1:0][XLEN-1:0]  fwd_data;
  logic                           stall_c;

  for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_port
    forward_match #(
      .DEPTH     (DEPTH),
      .LATE_STAGE(LATE_STAGE),
      .XLEN      (XLEN)
    ) u_match (
      .slots     (slot_q),
      .read_reg  (sb.readRegister[p]),
      .late_valid(sb.lateValid),
      .late_dest (sb.lateDest),
      .late_data (sb.lateData),
      .fwd_en_c  (fwd_en[p]),
      .fwd_data_c(fwd_data[p]),
      .stall_c   (port_stall[p])
    );
  end

  assign stall_c          = |port_stall;
  assign sb.stall         = stall_c;
  assign sb.forwardEnable = fwd_en;
  assign sb.forwardData   = fwd_data;

  // Late capture first, then shift, so a capture during advance lands one slot older.
  always_comb begin
    cap = slot_q;
    if (sb.lateValid && cap[LATE_STAGE].valid && !cap[LATE_STAGE].ready &&
        (cap[LATE_STAGE].dest == sb.lateDest)) begin
      cap[LATE_STAGE].ready = 1'b1;
      cap[LATE_STAGE].data  = SLOT_DATA_W'(sb.lateData);
    end
    slot_d = cap;
    if (sb.advance) begin
      for (int unsigned i = DEPTH - 1; i > 0; i--) begin
        slot_d[i] = cap[i-1];
      end
      slot_d[0] = '0;
      if (sb.issueValid && !stall_c && (sb.issueDest != '0)) begin
        slot_d[0].valid = 1'b1;
        slot_d[0].dest  = sb.issueDest;
        slot_d[0].ready = sb.issueReady;
        slot_d[0].data  = sb.issueReady ? SLOT_DATA_W'(sb.issueData) : '0;
      end
    end
    if (sb.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule : forward_scoreboard

// File: tb/tb_forward_scoreboard.sv
// Randomized and directed checks of forward_scoreboard against a queue-based
// model of the in-flight producer pipeline.
module tb_forward_scoreboard;
  import forward_scoreboard_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned D  = 3;
  localparam int unsigned LS = 1;
  localparam int unsigned XL = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  forward_scoreboard_if #(.NUM_READ(NR), .XLEN(XL)) sb ();

  forward_scoreboard #(
    .NUM_READ(NR), .DEPTH(D), .LATE_STAGE(LS), .XLEN(XL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sb   (sb)
  );

  typedef struct packed {
    bit        v;
    bit [4:0]  d;
    bit        r;
    bit [31:0] x;
  } rec_t;

  rec_t m [$];   // m[0] youngest producer
  int   checks = 0;
  int   passes = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endfunction

  // Expected result of one read port from the model and the current inputs.
  function automatic void model_port(input bit [4:0] rr, output bit en,
                                     output bit [31:0] dat, output bit st);
    en = 0; dat = 0; st = 0;
    if (rr == 0) return;
    for (int i = 0; i < int'(D); i++) begin
      if (m[i].v && m[i].d == rr) begin
        if (m[i].r) begin en = 1; dat = m[i].x; end
        else if (i == int'(LS) && sb.lateValid && sb.lateDest == rr) begin
          en = 1; dat = sb.lateData;
        end else st = 1;
        return;
      end
    end
  endfunction

  // Compare every cycle, then advance the model to the state after the next edge.
  initial begin
    bit        en, st, st_all;
    bit [31:0] dat;
    rec_t      n;
    for (int i = 0; i < int'(D); i++) m.push_back('0);
    forever begin
      @(negedge clock);
      st_all = 0;
      for (int p = 0; p < int'(NR); p++) begin
        model_port(sb.readRegister[p], en, dat, st);
        st_all |= st;
        chk($sformatf("en%0d", p), 64'(sb.forwardEnable[p]), 64'(en));
        chk($sformatf("data%0d", p), 64'(sb.forwardData[p]), 64'(dat));
      end
      chk("stall", 64'(sb.stall), 64'(st_all));
      if (reset) begin
        foreach (m[i]) m[i] = '0;
      end else begin
        if (sb.lateValid && m[LS].v && !m[LS].r && m[LS].d == sb.lateDest) begin
          m[LS].r = 1; m[LS].x = sb.lateData;
        end
        if (sb.flush) begin
          foreach (m[i]) m[i].v = 0;
        end else if (sb.advance) begin
          n = '0;
          if (sb.issueValid && !st_all && sb.issueDest != 0)
            n = '{1'b1, sb.issueDest, sb.issueReady, sb.issueReady ? sb.issueData : 32'h0};
          m.push_front(n);
          void'(m.pop_back());
        end
      end
    end
  end

  task automatic idle();
    sb.advance = 0; sb.flush = 0; sb.issueValid = 0; sb.issueDest = 0;
    sb.issueReady = 0; sb.issueData = 0; sb.lateValid = 0; sb.lateDest = 0;
    sb.lateData = 0; sb.readRegister = '0;
  endtask

  task automatic nxt();
    @(posedge clock); #1;
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  task automatic issue(input bit [4:0] d, input bit rdy, input bit [31:0] x);
    sb.advance = 1; sb.issueValid = 1; sb.issueDest = d;
    sb.issueReady = rdy; sb.issueData = x;
  endtask

  initial begin
    reset = 1; idle();
    nxt(); nxt();
    reset = 0;
    settle();
    chk("reset_en", 64'(sb.forwardEnable), 64'(0));
    chk("reset_stall", 64'(sb.stall), 64'(0));
    nxt();

    // ALU chain
    issue(5, 1, 32'h11); nxt();
    idle(); sb.readRegister[0] = 5; settle();
    chk("alu_en", 64'(sb.forwardEnable[0]), 64'(1));
    chk("alu_data", 64'(sb.forwardData[0]), 64'h11);
    chk("alu_stall", 64'(sb.stall), 64'(0));
    nxt();

    // Youngest producer wins
    idle(); issue(7, 1, 32'hA); nxt();
    issue(7, 1, 32'hB); nxt();
    idle(); sb.readRegister[1] = 7; settle();
    chk("prio_data", 64'(sb.forwardData[1]), 64'hB);
    nxt();

    // Load-use with bubble insertion, then late forward
    idle(); issue(3, 0, 32'h0); nxt();
    idle(); sb.readRegister[0] = 3; settle();
    chk("lu_stall", 64'(sb.stall), 64'(1));
    chk("lu_en", 64'(sb.forwardEnable[0]), 64'(0));
    nxt();
    issue(9, 1, 32'h99); sb.readRegister[0] = 3; nxt();
    idle(); sb.readRegister[0] = 3; sb.readRegister[1] = 9;
    sb.lateValid = 1; sb.lateDest = 3; sb.lateData = 32'hDEAD; settle();
    chk("late_en", 64'(sb.forwardEnable[0]), 64'(1));
    chk("late_data", 64'(sb.forwardData[0]), 64'hDEAD);
    chk("late_stall", 64'(sb.stall), 64'(0));
    chk("bubble_en", 64'(sb.forwardEnable[1]), 64'(0));
    nxt();
    sb.lateValid = 0; sb.lateData = 0; settle();
    chk("slot_data", 64'(sb.forwardData[0]), 64'hDEAD);
    nxt();

    // Flush and x0
    idle(); issue(9, 1, 32'h99); nxt();
    idle(); sb.flush = 1; nxt();
    idle(); sb.readRegister[1] = 9; settle();
    chk("flush_en", 64'(sb.forwardEnable[1]), 64'(0));
    nxt();
    idle(); issue(0, 1, 32'h77); nxt();
    idle(); settle();
    chk("x0_en", 64'(sb.forwardEnable[0]), 64'(0));
    chk("x0_data", 64'(sb.forwardData[0]), 64'(0));
    nxt();

    // Reset mid-operation, then retirement
    issue(4, 1, 32'h1); nxt();
    issue(6, 0, 32'h0); nxt();
    issue(8, 1, 32'h3); nxt();
    idle(); reset = 1; nxt();
    reset = 0; sb.readRegister[0] = 4; sb.readRegister[1] = 6; settle();
    chk("rst_en", 64'(sb.forwardEnable), 64'(0));
    chk("rst_stall", 64'(sb.stall), 64'(0));
    nxt();
    idle(); issue(10, 1, 32'h55); nxt();
    idle(); sb.advance = 1; sb.readRegister[0] = 10;
    for (int k = 0; k < int'(D); k++) nxt();
    sb.advance = 0; settle();
    chk("retire_en", 64'(sb.forwardEnable[0]), 64'(0));
    nxt();

    // Randomized traffic on a small register set
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 99) == 0);
      sb.advance    = ($urandom_range(0, 3) != 0);
      sb.flush      = ($urandom_range(0, 39) == 0);
      sb.issueValid = ($urandom_range(0, 3) != 0);
      sb.issueDest  = 5'($urandom_range(0, 6));
      sb.issueReady = ($urandom_range(0, 2) != 0);
      sb.issueData  = $urandom;
      sb.lateValid  = ($urandom_range(0, 2) == 0);
      sb.lateDest   = ($urandom_range(0, 3) != 0) ? m[LS].d : 5'($urandom_range(1, 6));
      sb.lateData   = $urandom;
      for (int p = 0; p < int'(NR); p++)
        sb.readRegister[p] = 5'($urandom_range(0, 6));
      nxt();
    end
    reset = 0; idle();
    settle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_forward_scoreboard
